// File: rtl/pkt_demux_avlstrm_4_if.sv
`default_nettype none
// Avalon-ST stream bundle: data, valid/ready handshake, packet framing and empty byte count.
interface avl_stream_if #(
  parameter int DATA_BITS = 512
);
  localparam int EMPTY_BITS = $clog2(DATA_BITS / 8);

  logic [DATA_BITS-1:0]  data;
  logic                  valid;
  logic                  ready;
  logic                  sop;
  logic                  eop;
  logic [EMPTY_BITS-1:0] empty;

  modport tx (output data, valid, sop, eop, empty, input ready);
  modport rx (input data, valid, sop, eop, empty, output ready);
endinterface
`default_nettype wire

// File: rtl/pkt_demux_avlstrm_4.sv
`default_nettype none
// Packet-atomic 1-to-4 Avalon-ST demultiplexer with one-beat output stages,
// drop of packets aimed at disabled outputs, and saturating drop/error counters.
module pkt_demux_avlstrm_4 #(
  parameter int DATA_BITS = 512,
  parameter int CNT_BITS  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  avl_stream_if.rx            in,
  input  logic [1:0]          in_sel,
  input  logic [3:0]          out_en,
  avl_stream_if.tx            out0,
  avl_stream_if.tx            out1,
  avl_stream_if.tx            out2,
  avl_stream_if.tx            out3,
  output logic [CNT_BITS-1:0] drop_cnt,
  output logic [CNT_BITS-1:0] err_cnt
);
  localparam int EMPTY_BITS = $clog2(DATA_BITS / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] dest, dest_nxt;
  logic [3:0] vld, odr, acc, load;
  logic       ready, accept, drop_inc, err_inc;

  assign odr = {out3.ready, out2.ready, out1.ready, out0.ready};
  assign acc = ~vld | odr;

  // Any SOP beat is routed by its own in_sel, even when it cuts off an unterminated packet.
  always_comb begin
    ready = 1'b1;
    if (in.sop) begin
      ready = out_en[in_sel] ? acc[in_sel] : 1'b1;
    end else if (state == FWD) begin
      ready = acc[dest];
    end
    if (!rst_n) begin
      ready = 1'b0;
    end
  end

  assign accept   = in.valid && ready;
  assign in.ready = ready;

  always_comb begin
    state_nxt = state;
    dest_nxt  = dest;
    load      = 4'b0000;
    drop_inc  = 1'b0;
    err_inc   = 1'b0;
    if (accept) begin
      if (in.sop) begin
        err_inc = (state != IDLE);
        if (out_en[in_sel]) begin
          load[in_sel] = 1'b1;
          dest_nxt     = in_sel;
          state_nxt    = in.eop ? IDLE : FWD;
        end else begin
          drop_inc  = 1'b1;
          state_nxt = in.eop ? IDLE : DROP;
        end
      end else begin
        case (state)
          FWD: begin
            load[dest] = 1'b1;
            if (in.eop) state_nxt = IDLE;
          end
          DROP: begin
            if (in.eop) state_nxt = IDLE;
          end
          default: err_inc = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dest     <= 2'd0;
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      state <= state_nxt;
      dest  <= dest_nxt;
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_BITS'(1);
      if (err_inc && (err_cnt != '1))   err_cnt  <= err_cnt + CNT_BITS'(1);
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_stage
    logic                  v;
    logic                  sop_q;
    logic                  eop_q;
    logic [DATA_BITS-1:0]  data_q;
    logic [EMPTY_BITS-1:0] empty_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v       <= 1'b0;
        sop_q   <= 1'b0;
        eop_q   <= 1'b0;
        data_q  <= '0;
        empty_q <= '0;
      end else if (load[k]) begin
        v       <= 1'b1;
        sop_q   <= in.sop;
        eop_q   <= in.eop;
        data_q  <= in.data;
        empty_q <= in.empty;
      end else if (odr[k]) begin
        v <= 1'b0;
      end
    end
  end

  assign vld = {g_stage[3].v, g_stage[2].v, g_stage[1].v, g_stage[0].v};

  assign out0.valid = g_stage[0].v;
  assign out0.data  = g_stage[0].data_q;
  assign out0.sop   = g_stage[0].sop_q;
  assign out0.eop   = g_stage[0].eop_q;
  assign out0.empty = g_stage[0].empty_q;

  assign out1.valid = g_stage[1].v;
  assign out1.data  = g_stage[1].data_q;
  assign out1.sop   = g_stage[1].sop_q;
  assign out1.eop   = g_stage[1].eop_q;
  assign out1.empty = g_stage[1].empty_q;

  assign out2.valid = g_stage[2].v;
  assign out2.data  = g_stage[2].data_q;
  assign out2.sop   = g_stage[2].sop_q;
  assign out2.eop   = g_stage[2].eop_q;
  assign out2.empty = g_stage[2].empty_q;

  assign out3.valid = g_stage[3].v;
  assign out3.data  = g_stage[3].data_q;
  assign out3.sop   = g_stage[3].sop_q;
  assign out3.eop   = g_stage[3].eop_q;
  assign out3.empty = g_stage[3].empty_q;
endmodule
`default_nettype wire

// File: tb/tb_pkt_demux_avlstrm_4.sv
`default_nettype none
// Directed testbench for pkt_demux_avlstrm_4 with hand-computed expectations.
module tb_pkt_demux_avlstrm_4;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    in_sel;
  logic [3:0]    out_en;
  logic [3:0]    ordy;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  avl_stream_if #(.DATA_BITS(DW)) in_if ();
  avl_stream_if #(.DATA_BITS(DW)) out_if0 ();
  avl_stream_if #(.DATA_BITS(DW)) out_if1 ();
  avl_stream_if #(.DATA_BITS(DW)) out_if2 ();
  avl_stream_if #(.DATA_BITS(DW)) out_if3 ();

  assign out_if0.ready = ordy[0];
  assign out_if1.ready = ordy[1];
  assign out_if2.ready = ordy[2];
  assign out_if3.ready = ordy[3];

  logic [3:0]    ov, osop, oeop;
  logic [DW-1:0] od [4];
  logic [1:0]    oemp [4];

  assign ov   = {out_if3.valid, out_if2.valid, out_if1.valid, out_if0.valid};
  assign osop = {out_if3.sop, out_if2.sop, out_if1.sop, out_if0.sop};
  assign oeop = {out_if3.eop, out_if2.eop, out_if1.eop, out_if0.eop};
  assign od[0] = out_if0.data;
  assign od[1] = out_if1.data;
  assign od[2] = out_if2.data;
  assign od[3] = out_if3.data;
  assign oemp[0] = out_if0.empty;
  assign oemp[1] = out_if1.empty;
  assign oemp[2] = out_if2.empty;
  assign oemp[3] = out_if3.empty;

  pkt_demux_avlstrm_4 #(.DATA_BITS(DW), .CNT_BITS(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in_if),
    .in_sel   (in_sel),
    .out_en   (out_en),
    .out0     (out_if0),
    .out1     (out_if1),
    .out2     (out_if2),
    .out3     (out_if3),
    .drop_cnt (drop_cnt),
    .err_cnt  (err_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic s, input logic e,
                       input logic [1:0] emp, input logic [1:0] sel);
    in_if.valid = v;
    in_if.data  = d;
    in_if.sop   = s;
    in_if.eop   = e;
    in_if.empty = emp;
    in_sel      = sel;
    #1;
  endtask

  task automatic chk_beat(input string tag, input int k, input logic [DW-1:0] d,
                          input logic s, input logic e, input logic [1:0] emp);
    chk({tag, ".valid"}, 64'(ov), 64'd1 << k);
    chk({tag, ".data"},  64'(od[k]), 64'(d));
    chk({tag, ".sop"},   64'(osop[k]), 64'(s));
    chk({tag, ".eop"},   64'(oeop[k]), 64'(e));
    chk({tag, ".empty"}, 64'(oemp[k]), 64'(emp));
  endtask

  initial begin
    ordy   = 4'hF;
    out_en = 4'b1110;
    // SOP aimed at a disabled output would normally see ready=1; reset must hold it low.
    drive(1'b1, 32'hDEAD0000, 1'b1, 1'b1, 2'd0, 2'd0);
    tick();
    tick();
    chk("rst.ready", 64'(in_if.ready), 64'd0);
    chk("rst.valid", 64'(ov), 64'd0);
    chk("rst.drop",  64'(drop_cnt), 64'd0);
    chk("rst.err",   64'(err_cnt), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 2'd0);
    out_en = 4'hF;
    rst_n  = 1'b1;
    tick();
    chk("post_rst.valid", 64'(ov), 64'd0);

    // 3-beat packet to out2
    drive(1'b1, 32'hA0000001, 1'b1, 1'b0, 2'd0, 2'd2);
    chk("t1.ready", 64'(in_if.ready), 64'd1);
    tick();
    chk_beat("t1.b0", 2, 32'hA0000001, 1'b1, 1'b0, 2'd0);
    drive(1'b1, 32'hA0000002, 1'b0, 1'b0, 2'd0, 2'd2);
    tick();
    chk_beat("t1.b1", 2, 32'hA0000002, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 32'hA0000003, 1'b0, 1'b1, 2'd3, 2'd2);
    tick();
    chk_beat("t1.b2", 2, 32'hA0000003, 1'b0, 1'b1, 2'd3);
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    chk("t1.idle", 64'(ov), 64'd0);

    // back-to-back single-beat packets to each output
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h100 + 32'(k), 1'b1, 1'b1, 2'(k), 2'(k));
      chk("t2.ready", 64'(in_if.ready), 64'd1);
      tick();
      chk_beat("t2.beat", k, 32'h100 + 32'(k), 1'b1, 1'b1, 2'(k));
    end
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    chk("t2.idle", 64'(ov), 64'd0);

    // backpressure on out1
    ordy = 4'b1101;
    drive(1'b1, 32'h31, 1'b1, 1'b0, 2'd0, 2'd1);
    chk("t3.ready0", 64'(in_if.ready), 64'd1);
    tick();
    chk_beat("t3.b0", 1, 32'h31, 1'b1, 1'b0, 2'd0);
    drive(1'b1, 32'h32, 1'b0, 1'b0, 2'd0, 2'd1);
    chk("t3.ready1", 64'(in_if.ready), 64'd0);
    tick();
    chk_beat("t3.hold", 1, 32'h31, 1'b1, 1'b0, 2'd0);
    ordy = 4'hF;
    #1;
    chk("t3.ready2", 64'(in_if.ready), 64'd1);
    tick();
    chk_beat("t3.b1", 1, 32'h32, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 32'h33, 1'b0, 1'b0, 2'd0, 2'd1);
    tick();
    chk_beat("t3.b2", 1, 32'h33, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 32'h34, 1'b0, 1'b1, 2'd2, 2'd1);
    tick();
    chk_beat("t3.b3", 1, 32'h34, 1'b0, 1'b1, 2'd2);
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    chk("t3.idle", 64'(ov), 64'd0);

    // packet to disabled out1 is dropped; re-enabling mid-packet changes nothing
    out_en = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h40 + 32'(i), (i == 0), (i == 4), 2'd0, 2'd1);
      chk("t4.ready", 64'(in_if.ready), 64'd1);
      tick();
      chk("t4.novalid", 64'(ov), 64'd0);
      out_en = 4'hF;
    end
    chk("t4.drop", 64'(drop_cnt), 64'd1);
    chk("t4.err",  64'(err_cnt), 64'd0);
    drive(1'b1, 32'h4F, 1'b1, 1'b1, 2'd1, 2'd0);
    tick();
    chk_beat("t4.next", 0, 32'h4F, 1'b1, 1'b1, 2'd1);

    // framing errors: stray non-SOP beat, then SOP without EOP
    drive(1'b1, 32'h50, 1'b0, 1'b0, 2'd0, 2'd3);
    chk("t5.ready", 64'(in_if.ready), 64'd1);
    tick();
    chk("t5.stray", 64'(ov), 64'd0);
    chk("t5.err1",  64'(err_cnt), 64'd1);
    drive(1'b1, 32'h51, 1'b1, 1'b0, 2'd0, 2'd2);
    tick();
    chk_beat("t5.p1", 2, 32'h51, 1'b1, 1'b0, 2'd0);
    drive(1'b1, 32'h52, 1'b1, 1'b0, 2'd0, 2'd3);
    tick();
    chk("t5.err2", 64'(err_cnt), 64'd2);
    chk_beat("t5.p2", 3, 32'h52, 1'b1, 1'b0, 2'd0);
    drive(1'b1, 32'h53, 1'b0, 1'b1, 2'd0, 2'd0);
    tick();
    chk_beat("t5.p2e", 3, 32'h53, 1'b0, 1'b1, 2'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    chk("t5.idle", 64'(ov), 64'd0);
    chk("t5.drop", 64'(drop_cnt), 64'd1);

    // drop counter saturates at 3 with a 2-bit width
    out_en = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h60 + 32'(i), 1'b1, 1'b1, 2'd0, 2'd0);
      tick();
      chk("t6.novalid", 64'(ov), 64'd0);
      chk("t6.drop", 64'(drop_cnt), (i + 2 > 3) ? 64'd3 : 64'(i + 2));
    end
    chk("t6.err", 64'(err_cnt), 64'd2);

    // asynchronous reset mid-packet
    out_en = 4'hF;
    drive(1'b1, 32'h70, 1'b1, 1'b0, 2'd0, 2'd0);
    tick();
    chk_beat("t7.b0", 0, 32'h70, 1'b1, 1'b0, 2'd0);
    drive(1'b1, 32'h71, 1'b0, 1'b0, 2'd0, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7.valid", 64'(ov), 64'd0);
    chk("t7.ready", 64'(in_if.ready), 64'd0);
    chk("t7.drop",  64'(drop_cnt), 64'd0);
    chk("t7.err",   64'(err_cnt), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 32'h72, 1'b1, 1'b1, 2'd0, 2'd3);
    chk("t7.ready2", 64'(in_if.ready), 64'd1);
    tick();
    chk_beat("t7.fresh", 3, 32'h72, 1'b1, 1'b1, 2'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    chk("t7.idle", 64'(ov), 64'd0);
    chk("t7.err2", 64'(err_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pkt_demux_avlstrm_4.md
Name: pkt_demux_avlstrm_4

Overview:
- Packet-atomic 1-to-4 Avalon-ST demultiplexer; the return-direction counterpart of the packet mux tree.
- Takes one stream, reads a destination select on each SOP beat, and steers the whole packet (SOP..EOP) to one of four output streams.
- Each output has a one-beat registered stage.
- Packets aimed at a disabled output are consumed and dropped.
- Framing violations are counted.

Parameters:
- DATA_BITS, 512, data width of all streams (empty width is log2(DATA_BITS/8) = 6 at default).
- CNT_BITS, 32, width of the saturating statistics counters.

Ports:
- Clk  input  1  clock.
- Rst_n  input  1  reset; asynchronous, active-low.
- in  avl_stream_if.rx  DATA_BITS+sideband  input stream (data, valid, ready, sop, eop, empty).
- in_sel  input  2  destination index; qualified only on in.valid && in.sop.
- out_en  input  4  per-output enable; sampled at SOP acceptance.
- out0..out3  avl_stream_if.tx  DATA_BITS+sideband  output streams.
- drop_cnt  output  CNT_BITS  packets dropped because their target was disabled.
- err_cnt  output  CNT_BITS  framing errors.

Behaviour:
- Reset: state=IDLE, dest=0; all outK.valid=0; data/sop/eop/empty registers=0; in.ready=0 during reset; drop_cnt=0, err_cnt=0.
- Output stage K: holds one beat, register vK.
  - accK = !vK || outK.ready.
  - On load: vK<=1 and the beat is copied.
  - On outK.ready with no load: vK<=0.
  - Load and drain in the same cycle: the new beat replaces the old one, vK stays 1.
  - Latency from in handshake to outK.valid is 1 cycle.
  - Full throughput of 1 beat/cycle per output while outK.ready=1.
- State IDLE:
  - in.ready = accK for K=in_sel, or 1 if out_en[in_sel]=0.
  - Accept with sop=1, out_en[in_sel]=1: load stage in_sel, dest<=in_sel. If eop=1, stay IDLE (single-beat packet); else go to FWD.
  - Accept with sop=1, out_en[in_sel]=0: beat discarded; drop_cnt++ (saturating). If eop=0, go to DROP.
  - Accept with sop=0: beat discarded, err_cnt++, stay IDLE. in.ready=1 in this case.
- State FWD:
  - in.ready = acc[dest]; beats load stage dest.
  - eop=1 -> IDLE.
  - sop=1 (missing EOP): err_cnt++; the beat is treated as a new SOP in IDLE, re-evaluating in_sel and out_en (forward or drop). The stage-dest copy of the old packet is not altered.
- State DROP:
  - in.ready=1; beats discarded.
  - eop=1 -> IDLE.
  - sop=1: err_cnt++, treated as a new SOP as in FWD.
- out_en changes mid-packet have no effect; the decision is locked at SOP.
- Only the stage matching dest/in_sel ever loads; other outputs are never stalled by the active one.
- Counters saturate at all-ones; no wrap.
- Asynchronous reset mid-packet: an in-flight packet is truncated on all outputs (valid drops immediately) and state returns to IDLE. Upstream must restart on a packet boundary.
- sop and eop both set on a beat is legal: a single-beat packet.
- empty is passed through unchanged and is meaningful only with eop.

Test Plan:
1. 3-beat packet with in_sel=2, out_en=4'hF, all ready=1 -> out2 emits 3 beats on cycles N+1..N+3 with sop on the first and eop+empty on the last; out0/1/3 stay valid=0.
2. Back-to-back single-beat packets with in_sel=0,1,2,3 -> one beat on each output in order; in.ready stays 1 throughout.
3. out1.ready=0 while a 4-beat packet targets out1 -> stage fills; in.ready=0 from the second beat. Release ready -> all 4 beats delivered in order, none lost or duplicated.
4. out_en=4'b1101, 5-beat packet with in_sel=1 -> in.ready=1 for all 5 beats; no output valid; drop_cnt=1. Next packet to out0 forwards normally.
5. Non-SOP beat in IDLE, then SOP without prior EOP in FWD -> err_cnt=2; the second packet is routed per its own in_sel.
6. Assert Rst_n=0 mid-packet -> all outK.valid=0 asynchronously and counters=0. After release, a fresh packet forwards correctly.
